// File: rtl/serial_addend_recover.sv
// serial_addend_recover
//   Recovers addend A = S - B from a 5-bit sum S and a 4-bit addend B.
//   Three nibbles arrive on an asynchronous strobe handshake: S[3:0], then
//   S[4] (in nib[0]), then B. The difference is computed LSB-first through
//   a single full-subtractor and a borrow flop over 5 clocks.
//   This is a TinyTapeout tile, so all I/O is packed into two 8-bit buses.
//
// Ports
//   io_in[0]    clk    rising-edge clock
//   io_in[1]    rst_n  asynchronous active-low reset
//   io_in[2]    strb   async nibble strobe; each rising edge accepts one nibble
//   io_in[3]    abort  async level; returns the block to the load phase
//   io_in[7:4]  nib    operand nibble
//   io_out[3:0] a      recovered addend, (S-B) mod 16
//   io_out[4]   err    S < B or S - B > 15
//   io_out[5]   busy   high while the subtract is running
//   io_out[6]   done   result valid
//   io_out[7]   want_b next accepted nibble is B
module serial_addend_recover #(
  parameter int SYNC_STAGES = 2
) (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  typedef enum logic [2:0] {
    GET_SLO,
    GET_SHI,
    GET_B,
    CALC,
    DONE
  } state_t;

  logic       clk;
  logic       rst_n;
  logic       strb_raw;
  logic       abort_raw;
  logic [3:0] nib;

  assign clk       = io_in[0];
  assign rst_n     = io_in[1];
  assign strb_raw  = io_in[2];
  assign abort_raw = io_in[3];
  assign nib       = io_in[7:4];

  logic [SYNC_STAGES-1:0] strb_sync;
  logic [SYNC_STAGES-1:0] abort_sync;
  logic                   strb_d;
  logic                   accept;
  logic                   abort_level;

  state_t     state;
  logic [4:0] s;
  logic [4:0] b;
  logic [4:0] d;
  logic [2:0] cnt;
  logic       borrow;
  logic [3:0] a;
  logic       err;
  logic       busy;
  logic       done;
  logic       want_b;

  logic       d_bit;
  logic       borrow_next;
  logic [4:0] d_next;

  // Both async inputs go through a SYNC_STAGES-deep shift chain; the extra
  // strb_d flop turns the synchronized strobe into a single-cycle accept pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strb_sync  <= '0;
      abort_sync <= '0;
      strb_d     <= 1'b0;
    end else begin
      strb_sync  <= {strb_sync[SYNC_STAGES-2:0], strb_raw};
      abort_sync <= {abort_sync[SYNC_STAGES-2:0], abort_raw};
      strb_d     <= strb_sync[SYNC_STAGES-1];
    end
  end

  assign accept      = strb_sync[SYNC_STAGES-1] & ~strb_d;
  assign abort_level = abort_sync[SYNC_STAGES-1];

  // One full-subtractor slice; the new difference bit enters d at the MSB so
  // that after 5 shifts d[0] holds bit 0 of S - B.
  always_comb begin
    d_bit       = s[0] ^ b[0] ^ borrow;
    borrow_next = (~s[0] & b[0]) | (~(s[0] ^ b[0]) & borrow);
    d_next      = {d_bit, d[4:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= GET_SLO;
      s      <= '0;
      b      <= '0;
      d      <= '0;
      cnt    <= '0;
      borrow <= 1'b0;
      a      <= '0;
      err    <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      want_b <= 1'b0;
    end else if (abort_level) begin
      // Abort overrides any accept in the same cycle; a keeps the last result.
      state  <= GET_SLO;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      want_b <= 1'b0;
    end else begin
      case (state)
        GET_SLO: begin
          if (accept) begin
            s[3:0] <= nib;
            state  <= GET_SHI;
          end
        end
        GET_SHI: begin
          if (accept) begin
            s[4]   <= nib[0];
            state  <= GET_B;
            want_b <= 1'b1;
          end
        end
        GET_B: begin
          if (accept) begin
            b      <= {1'b0, nib};
            d      <= '0;
            cnt    <= '0;
            borrow <= 1'b0;
            state  <= CALC;
            want_b <= 1'b0;
            busy   <= 1'b1;
          end
        end
        CALC: begin
          // Strobes arriving here are simply not looked at.
          s      <= {1'b0, s[4:1]};
          b      <= {1'b0, b[4:1]};
          d      <= d_next;
          borrow <= borrow_next;
          cnt    <= cnt + 3'd1;
          if (cnt == 3'd4) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            a     <= d_next[3:0];
            err   <= borrow_next | d_next[4];
          end
        end
        DONE: begin
          if (accept) begin
            s[3:0] <= nib;
            done   <= 1'b0;
            err    <= 1'b0;
            state  <= GET_SHI;
          end
        end
        default: state <= GET_SLO;
      endcase
    end
  end

  assign io_out = {want_b, done, busy, err, a};

endmodule

// File: tb/tb_serial_addend_recover.sv
// tb_serial_addend_recover
//   Self-checking bench for serial_addend_recover. Expected {a, err} pairs
//   are computed from plain integer arithmetic and queued when B is sent; a
//   monitor pops and compares them whenever done rises, and also checks that
//   busy was high for exactly 5 clocks before it.
module tb_serial_addend_recover;

  localparam int SYNC_STAGES = 2;

  typedef struct packed {
    logic [3:0] a;
    logic       err;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       strb = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] nib = 4'h0;
  logic [7:0] io_in;
  logic [7:0] io_out;

  logic [3:0] a;
  logic       err;
  logic       busy;
  logic       done;
  logic       want_b;

  int   compared = 0;
  int   mismatched = 0;
  exp_t exp_q[$];

  assign io_in  = {nib, abort, strb, rst_n, clk};
  assign a      = io_out[3:0];
  assign err    = io_out[4];
  assign busy   = io_out[5];
  assign done   = io_out[6];
  assign want_b = io_out[7];

  serial_addend_recover #(
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .io_in (io_in),
    .io_out(io_out)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expv);
    compared++;
    if (got !== expv) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, expv);
    end
  endtask

  task automatic send_nibble(input logic [3:0] n, input int hi, input int lo);
    @(negedge clk);
    nib  = n;
    strb = 1'b1;
    repeat (hi) @(negedge clk);
    strb = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic wait_done(input string tag);
    int waited;
    waited = 0;
    while (!done && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checkOutput(tag, {31'd0, done}, 32'd1);
  endtask

  task automatic wait_busy(input string tag);
    int waited;
    waited = 0;
    while (!busy && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checkOutput(tag, {31'd0, busy}, 32'd1);
  endtask

  function automatic exp_t model(input int sv, input int bv);
    exp_t e;
    int   diff;
    diff  = sv - bv;
    e.a   = 4'(diff & 15);
    e.err = (diff < 0) || (diff > 15);
    return e;
  endfunction

  // Full S/B transaction; nib[3:1] of the S-high nibble carries junk on purpose.
  task automatic applyStimulus(input logic [4:0] sv, input logic [3:0] bv);
    send_nibble(sv[3:0], 4, 4);
    send_nibble({3'b101, sv[4]}, 4, 4);
    checkOutput("want_b_before_b", {31'd0, want_b}, 32'd1);
    exp_q.push_back(model(int'(sv), int'(bv)));
    send_nibble(bv, 4, 4);
    wait_done("done_timeout");
  endtask

  // Scoreboard side: compares on every rising edge of done.
  logic done_q = 1'b0;
  logic busy_q = 1'b0;
  int   busy_len = 0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      done_q   = 1'b0;
      busy_q   = 1'b0;
      busy_len = 0;
    end else begin
      if (busy && !busy_q) busy_len = 1;
      else if (busy) busy_len++;
      if (done && !done_q) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("result_a", {28'd0, a}, {28'd0, e.a});
          checkOutput("result_err", {31'd0, err}, {31'd0, e.err});
          checkOutput("busy_len", busy_len, 32'd5);
        end
      end
      done_q = done;
      busy_q = busy;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got running, expected finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    exp_t saved;

    // Reset values
    repeat (3) @(negedge clk);
    checkOutput("reset_io_out", {24'd0, io_out}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("post_reset_io_out", {24'd0, io_out}, 32'd0);

    // Plain case, borrow case, overflow case
    applyStimulus(5'h13, 4'h7);
    applyStimulus(5'h05, 4'h9);
    applyStimulus(5'h1F, 4'h0);

    // New S nibble from DONE clears done/err but keeps a
    send_nibble(4'h3, 4, 4);
    checkOutput("reload_done", {31'd0, done}, 32'd0);
    checkOutput("reload_err", {31'd0, err}, 32'd0);
    checkOutput("reload_a", {28'd0, a}, 32'hF);

    // Back to GET_SLO via abort
    @(negedge clk);
    abort = 1'b1;
    repeat (4) @(negedge clk);
    abort = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("abort_want_b", {31'd0, want_b}, 32'd0);

    // Held strobe gives one accept only
    send_nibble(4'h6, 20, 4);
    checkOutput("held_strb_want_b", {31'd0, want_b}, 32'd0);
    send_nibble(4'h1, 4, 4);
    checkOutput("second_accept_want_b", {31'd0, want_b}, 32'd1);
    exp_q.push_back(model(32'h16, 2));
    send_nibble(4'h2, 4, 4);
    wait_done("held_done_timeout");

    // Abort in the middle of CALC
    send_nibble(4'h9, 4, 4);
    send_nibble(4'h1, 4, 4);
    @(negedge clk);
    nib  = 4'h3;
    strb = 1'b1;
    wait_busy("abort_busy_timeout");
    abort = 1'b1;
    repeat (3) @(negedge clk);
    strb  = 1'b0;
    abort = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    checkOutput("abort_done", {31'd0, done}, 32'd0);
    checkOutput("abort_err", {31'd0, err}, 32'd0);
    checkOutput("abort_a", {28'd0, a}, 32'h4);
    applyStimulus(5'h10, 4'h1);

    // Async reset mid-CALC
    send_nibble(4'hA, 4, 4);
    send_nibble(4'h1, 4, 4);
    @(negedge clk);
    nib  = 4'h2;
    strb = 1'b1;
    wait_busy("rst_busy_timeout");
    strb = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 checkOutput("async_reset_io_out", {24'd0, io_out}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Strobe pulse during CALC must be dropped
    send_nibble(4'h8, 4, 4);
    send_nibble(4'h1, 4, 4);
    exp_q.push_back(model(32'h18, 3));
    send_nibble(4'h3, 3, 1);
    send_nibble(4'hA, 2, 6);
    wait_done("calc_strb_done_timeout");
    checkOutput("calc_strb_want_b", {31'd0, want_b}, 32'd0);
    saved = model(32'h0C, 5);
    applyStimulus(5'h0C, 4'h5);
    checkOutput("final_a", {28'd0, a}, {28'd0, saved.a});

    repeat (2) @(negedge clk);
    checkOutput("scoreboard_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
